// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - four-requester round-robin arbiter with hold-until-release and grant watchdog
// Break-before-make: every grant is followed by one all-zero GAP cycle.
module rr_arbiter_4 #(
  parameter int TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  output logic [3:0] o_grant,
  output logic [1:0] o_gnt_idx,
  output logic       o_gnt_valid,
  output logic       o_timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam bit         LP_WD_EN = (TIMEOUT != 0);
  localparam logic [7:0] LP_LAST  = 8'(TIMEOUT - 1);

  state_t     r_state;
  logic [1:0] r_ptr;
  logic [1:0] r_idx;
  logic [7:0] r_cnt;
  logic [3:0] r_grant;
  logic       r_gnt_valid;
  logic       r_timeout;

  logic [1:0] w_winner;
  logic [1:0] w_cand;
  logic       w_held;
  logic       w_expire;

  // Scan from the lowest priority upward so the last hit is the nearest to r_ptr.
  always_comb begin
    w_winner = r_ptr;
    w_cand   = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_cand = r_ptr + 2'(k);
      if (i_req[w_cand]) w_winner = w_cand;
    end
  end

  assign w_held   = i_req[r_idx];
  assign w_expire = LP_WD_EN && (r_cnt == LP_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= 2'd0;
      r_idx       <= 2'd0;
      r_cnt       <= 8'd0;
      r_grant     <= 4'b0000;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE, S_GAP: begin
          if (|i_req) begin
            r_state     <= S_GRANT;
            r_idx       <= w_winner;
            r_cnt       <= 8'd0;
            r_grant     <= 4'b0001 << w_winner;
            r_gnt_valid <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_GRANT: begin
          if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
          // A release on the expiry cycle wins, so no timeout pulse then.
          if (!w_held || w_expire) begin
            r_state     <= S_GAP;
            r_ptr       <= r_idx + 2'd1;
            r_grant     <= 4'b0000;
            r_gnt_valid <= 1'b0;
            r_timeout   <= w_held;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_grant     = r_grant;
  assign o_gnt_idx   = r_idx;
  assign o_gnt_valid = r_gnt_valid;
  assign o_timeout   = r_timeout;

endmodule
